// File: rtl/in_debounce_sync.sv
// Synchronises and debounces a raw asynchronous level, producing a clean level and edge pulses.
// Optional glitch counter is built when DEBOUNCE_GLITCH_CNT_EN is defined; otherwise glitch_cnt reads 0.
module in_debounce_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter int   DB_CYCLES   = 4,
    parameter logic RESET_VAL   = 1'b0,
    parameter int   CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             raw_in,
    input  logic             en,
    output logic             clean_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             busy,
    output logic [CNT_W-1:0] glitch_cnt
);

    localparam int            CW   = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    typedef enum logic {STABLE, CONFIRM} state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   clean_q, clean_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   busy_q, busy_d;

    // The synchroniser runs every cycle; en only gates the confirmation logic.
    always_comb sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        if (en && (s != clean_q)) begin
            if (state_q == STABLE) begin
                if (DB_CYCLES == 1) begin
                    clean_d = s;
                end else begin
                    cnt_d   = CW'(1);
                    state_d = CONFIRM;
                end
            end else if (cnt_q == LAST) begin
                clean_d = s;
                cnt_d   = '0;
                state_d = STABLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (en && (state_q == CONFIRM)) begin
            // Synced level fell back before confirmation completed: reject.
            cnt_d   = '0;
            state_d = STABLE;
        end
        rise_d = clean_d & ~clean_q;
        fall_d = ~clean_d & clean_q;
        busy_d = (state_d == CONFIRM);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= {SYNC_STAGES{RESET_VAL}};
            state_q <= STABLE;
            cnt_q   <= '0;
            clean_q <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    assign clean_out  = clean_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign busy       = busy_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic             glitch;
    logic [CNT_W-1:0] glitch_q, glitch_d;

    always_comb begin
        glitch   = en && (state_q == CONFIRM) && (s == clean_q);
        glitch_d = glitch_q;
        if (glitch && (glitch_q != '1)) begin
            glitch_d = glitch_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_cnt = glitch_q;
`else
    assign glitch_cnt = '0;
`endif

endmodule

// File: tb/tb_in_debounce_sync.sv
// Scoreboard bench for in_debounce_sync with default parameters (SYNC_STAGES=2, DB_CYCLES=4).
module tb_in_debounce_sync;

    localparam int CNT_W = 8;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             raw_in = 1'b0;
    logic             en = 1'b1;
    logic             clean_out, rise_pulse, fall_pulse, busy;
    logic [CNT_W-1:0] glitch_cnt;

    in_debounce_sync #(
        .SYNC_STAGES(2),
        .DB_CYCLES  (4),
        .RESET_VAL  (1'b0),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .raw_in    (raw_in),
        .en        (en),
        .clean_out (clean_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .busy      (busy),
        .glitch_cnt(glitch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       o;   // {clean, rise, fall, busy}
        logic [CNT_W-1:0] g;
    } exp_t;

    exp_t exp_q[$];
    int   compared = 0;
    int   failed   = 0;
    int   glitches = 0;

    function automatic logic [CNT_W-1:0] g_model(input int n);
        int sat;
        sat = (1 << CNT_W) - 1;
        if (!GC_EN) return '0;
        return (n > sat) ? CNT_W'(sat) : CNT_W'(n);
    endfunction

    function automatic void push(input logic c, input logic r, input logic f, input logic b, input int n);
        exp_t e;
        e.o = {c, r, f, b};
        e.g = g_model(n);
        exp_q.push_back(e);
    endfunction

    task automatic test_reset();
        exp_t e;
        #2 reset = 1'b1;
        #1;
        push(1'b0, 1'b0, 1'b0, 1'b0, 0);
        e = exp_q.pop_front();
        compared++;
        if ({clean_out, rise_pulse, fall_pulse, busy} !== e.o) begin
            failed++; $display("FAIL reset_async outs=%b required %b", {clean_out, rise_pulse, fall_pulse, busy}, e.o);
        end
        compared++;
        if (glitch_cnt !== e.g) begin
            failed++; $display("FAIL reset_async glitch_cnt=%0d required %0d", glitch_cnt, e.g);
        end
        for (int k = 1; k <= 5; k++) begin
            push(1'b0, 1'b0, 1'b0, 1'b0, 0);
            @(posedge clk); #1;
            if (k == 2) reset = 1'b0;
            e = exp_q.pop_front();
            compared++;
            if ({clean_out, rise_pulse, fall_pulse, busy} !== e.o) begin
                failed++; $display("FAIL reset_hold cyc%0d outs=%b required %b", k, {clean_out, rise_pulse, fall_pulse, busy}, e.o);
            end
            compared++;
            if (glitch_cnt !== e.g) begin
                failed++; $display("FAIL reset_hold cyc%0d glitch_cnt=%0d required %0d", k, glitch_cnt, e.g);
            end
        end
        glitches = 0;
    endtask

    // Level held from before edge 1: busy after edges 3..5, accepted at edge 6.
    task automatic test_accept(input logic dir, input string name);
        exp_t e;
        raw_in = dir;
        for (int k = 1; k <= 8; k++)
            push((k >= 6) ? dir : ~dir, dir && (k == 6), !dir && (k == 6), (k >= 3) && (k <= 5), glitches);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            compared++;
            if ({clean_out, rise_pulse, fall_pulse, busy} !== e.o) begin
                failed++; $display("FAIL %s cyc%0d outs=%b required %b", name, k, {clean_out, rise_pulse, fall_pulse, busy}, e.o);
            end
            compared++;
            if (glitch_cnt !== e.g) begin
                failed++; $display("FAIL %s cyc%0d glitch_cnt=%0d required %0d", name, k, glitch_cnt, e.g);
            end
        end
    endtask

    // Two-cycle pulse: confirm starts at edge 3, rejected at edge 5.
    task automatic test_glitch();
        exp_t e;
        for (int k = 1; k <= 7; k++)
            push(1'b0, 1'b0, 1'b0, (k >= 3) && (k <= 4), glitches + ((k >= 5) ? 1 : 0));
        for (int k = 1; k <= 7; k++) begin
            raw_in = (k <= 2);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            compared++;
            if ({clean_out, rise_pulse, fall_pulse, busy} !== e.o) begin
                failed++; $display("FAIL glitch cyc%0d outs=%b required %b", k, {clean_out, rise_pulse, fall_pulse, busy}, e.o);
            end
            compared++;
            if (glitch_cnt !== e.g) begin
                failed++; $display("FAIL glitch cyc%0d glitch_cnt=%0d required %0d", k, glitch_cnt, e.g);
            end
        end
        glitches++;
    endtask

    // en only on every 3rd edge: samples at edges 3,6,9,12, accepted on the 4th (edge 12).
    task automatic test_gated();
        exp_t e;
        raw_in = 1'b1;
        for (int k = 1; k <= 14; k++)
            push(k >= 12, k == 12, 1'b0, (k >= 3) && (k <= 11), glitches);
        for (int k = 1; k <= 14; k++) begin
            en = (k % 3 == 0);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            compared++;
            if ({clean_out, rise_pulse, fall_pulse, busy} !== e.o) begin
                failed++; $display("FAIL gated cyc%0d outs=%b required %b", k, {clean_out, rise_pulse, fall_pulse, busy}, e.o);
            end
            compared++;
            if (glitch_cnt !== e.g) begin
                failed++; $display("FAIL gated cyc%0d glitch_cnt=%0d required %0d", k, glitch_cnt, e.g);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        raw_in = 1'b1;
        for (int k = 1; k <= 4; k++)
            push(1'b0, 1'b0, 1'b0, k >= 3, glitches);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            compared++;
            if ({clean_out, rise_pulse, fall_pulse, busy} !== e.o) begin
                failed++; $display("FAIL rstmid_pre cyc%0d outs=%b required %b", k, {clean_out, rise_pulse, fall_pulse, busy}, e.o);
            end
        end
        reset = 1'b1;
        glitches = 0;
        #1;
        push(1'b0, 1'b0, 1'b0, 1'b0, 0);
        e = exp_q.pop_front();
        compared++;
        if ({clean_out, rise_pulse, fall_pulse, busy} !== e.o) begin
            failed++; $display("FAIL rstmid_async outs=%b required %b", {clean_out, rise_pulse, fall_pulse, busy}, e.o);
        end
        compared++;
        if (glitch_cnt !== e.g) begin
            failed++; $display("FAIL rstmid_async glitch_cnt=%0d required %0d", glitch_cnt, e.g);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 1; k <= 8; k++)
            push(k >= 6, k == 6, 1'b0, (k >= 3) && (k <= 5), 0);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            compared++;
            if ({clean_out, rise_pulse, fall_pulse, busy} !== e.o) begin
                failed++; $display("FAIL rstmid_post cyc%0d outs=%b required %b", k, {clean_out, rise_pulse, fall_pulse, busy}, e.o);
            end
            compared++;
            if (glitch_cnt !== e.g) begin
                failed++; $display("FAIL rstmid_post cyc%0d glitch_cnt=%0d required %0d", k, glitch_cnt, e.g);
            end
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        for (int n = 0; n < 300; n++) begin
            for (int k = 1; k <= 6; k++)
                push(1'b0, 1'b0, 1'b0, (k >= 3) && (k <= 4), glitches + ((k >= 5) ? 1 : 0));
            for (int k = 1; k <= 6; k++) begin
                raw_in = (k <= 2);
                @(posedge clk); #1;
                e = exp_q.pop_front();
                compared++;
                if ({clean_out, rise_pulse, fall_pulse, busy} !== e.o) begin
                    failed++; $display("FAIL sat g%0d cyc%0d outs=%b required %b", n, k, {clean_out, rise_pulse, fall_pulse, busy}, e.o);
                end
                compared++;
                if (glitch_cnt !== e.g) begin
                    failed++; $display("FAIL sat g%0d cyc%0d glitch_cnt=%0d required %0d", n, k, glitch_cnt, e.g);
                end
            end
            glitches++;
        end
    endtask

    initial begin
        test_reset();
        test_accept(1'b1, "rise");
        test_accept(1'b0, "fall");
        test_glitch();
        test_gated();
        test_accept(1'b0, "fall2");
        test_reset_mid();
        test_accept(1'b0, "fall3");
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached compared=%0d required completion", compared);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/in_debounce_sync.md
Name: in_debounce_sync

Overview:
Input conditioner that sits directly upstream of the single-bit toggle state machine and drives its `in` input. It takes a raw asynchronous level from a pad or switch, synchronises it into the clk domain, and debounces it. It outputs a clean level plus one-cycle rise/fall pulses. Short excursions that fail the confirmation window are rejected as glitches.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops; legal range 2..4.
DB_CYCLES, 4, consecutive enabled samples of a differing synced level needed to accept a change; must be >= 1.
RESET_VAL, 0, reset value of the synchroniser chain and of clean_out.
CNT_W, 8, width of glitch_cnt.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
raw_in  in  1  unsynchronised input level.
en  in  1  sample-enable tick; tie to 1 to sample every cycle.
clean_out  out  1  debounced level; feeds the downstream FSM `in`.
rise_pulse  out  1  one-clk pulse when clean_out goes 0->1.
fall_pulse  out  1  one-clk pulse when clean_out goes 1->0.
busy  out  1  high while a candidate change is being confirmed.
glitch_cnt  out  CNT_W  saturating count of rejected candidates; see Optional Feature.

Behaviour:
- Reset:
  - reset, asynchronous, active-high; clock clk.
  - On reset all sync flops go to RESET_VAL and clean_out goes to RESET_VAL.
  - rise_pulse, fall_pulse and busy go to 0; the confirm counter and glitch_cnt go to 0; state goes to STABLE.
  - Reset takes effect immediately, including mid-confirmation. After release a full confirmation is needed again.
- Synchroniser: a SYNC_STAGES-flop chain clocked every cycle regardless of en. Let s be the last stage.
- Confirm counter: width clog2(DB_CYCLES+1); it only advances on cycles with en=1.
- FSM has 2 states, STABLE and CONFIRM.
- STABLE:
  - en=1 and s!=clean_out: if DB_CYCLES==1, accept at once (toggle clean_out, stay STABLE). Otherwise set cnt<=1 and go to CONFIRM.
  - All other cases: hold.
- CONFIRM:
  - en=1 and s!=clean_out: if cnt==DB_CYCLES-1, toggle clean_out, set cnt<=0 and go to STABLE. Otherwise cnt<=cnt+1.
  - en=1 and s==clean_out: glitch. Set cnt<=0, go to STABLE, and increment glitch_cnt (saturating).
  - en=0: hold cnt and state.
- Latency: with en=1 and defaults, a raw_in change held stable before rising edge 1 appears on clean_out after edge SYNC_STAGES+DB_CYCLES = 6.
- Pulses:
  - rise_pulse/fall_pulse are registered and asserted on the same edge that updates clean_out, for exactly one clk.
  - Never both high; never high outside an accepted change.
- busy is a registered copy of (next state == CONFIRM), so it is high from the edge entering CONFIRM until the edge leaving it.
- All outputs are registered; there is no combinational path from raw_in to any output.

Optional Feature:
Macro: DEBOUNCE_GLITCH_CNT_EN.
- Defined: glitch_cnt counts rejected candidates, saturating at 2^CNT_W-1 and cleared only by reset.
- Undefined: no counter logic is built and glitch_cnt is tied to 0. All other behaviour is identical.

Test Plan:
1. Reset check: reset=1, raw_in=0, RESET_VAL=0 -> clean_out=0, rise_pulse=fall_pulse=0, busy=0, glitch_cnt=0. No pulse on release.
2. Accepted rise: defaults, en=1, raw_in 0->1 before edge 1 and held -> busy high after edges 3..5; clean_out=1 and rise_pulse=1 after edge 6; rise_pulse=0 after edge 7.
3. Rejected glitch: raw_in high for 2 cycles then low, macro defined -> clean_out stays 0, no pulse, glitch_cnt=1, busy returns to 0.
4. Gated sampling: raw_in held 1, en=1 every 3rd cycle -> clean_out toggles only on the 4th enabled sample after s goes high; cnt holds on en=0 cycles.
5. Reset during confirm: assert reset at cnt=2 -> all outputs return to reset values immediately. After release with raw_in still 1, clean_out rises 6 edges later.
6. Saturation: CNT_W=8, 300 glitches -> glitch_cnt=255. With macro undefined, same stimulus gives glitch_cnt=0.
